pc_npc_stage: RTL and testbench
===============================

// Module: pc_npc_stage
// PURPOSE
//   Fetch-side PC register, IF/ID pipeline register and next-PC select for the 5-stage MIPS core.
//   Consumes the ID-stage branch decision br from the branch comparator.
//   Drives the instruction-memory address and hands the fetched instruction to ID.
//   Delayed-branch semantics: the slot instruction is always fetched and never flushed.
// PARAMETERS
//   RESET_PC   32'h0000_3000   PC value loaded on reset
// PORTS
//   clk        in   1   single clock; all state updates on posedge
//   reset      in   1   synchronous, active-low reset
//   stall      in   1   hazard unit: hold PC and IF/ID this cycle
//   npc_op     in   2   ID-stage control: 0 seq, 1 cond branch, 2 j/jal, 3 jr/jalr
//   br         in   1   comparator result for the instruction in ID (valid when npc_op==1)
//   rs_fwd     in   32  forwarded GPR[rs] for jr/jalr
//   instr_if   in   32  instruction read from IM at pc_if
//   pc_if      out  32  current fetch PC (IM address)
//   instr_id   out  32  IF/ID instruction register
//   pc4_id     out  32  IF/ID PC+4 register
//   pc8_id     out  32  pc4_id + 4 (link address for jal/jalr), combinational
//   redirect   out  1   npc != pc_if + 4 this cycle (debug/perf), combinational
// BEHAVIOUR
//   Reset (reset==0 at posedge): pc_if <= RESET_PC; instr_id <= 32'h0 (nop); pc4_id <= 32'h0.
//   reset has priority over stall and all other inputs.
//   Combinational targets, 32-bit wrap-around arithmetic, no overflow detection:
//     seq  = pc_if + 4
//     btgt = pc4_id + {{14{instr_id[15]}}, instr_id[15:0], 2'b00}
//     jtgt = {pc4_id[31:28], instr_id[25:0], 2'b00}
//     rtgt = rs_fwd (low two bits passed through unchanged; alignment is not checked here)
//   npc selection:
//     npc_op 0 -> seq
//     npc_op 1 -> br ? btgt : seq
//     npc_op 2 -> jtgt
//     npc_op 3 -> rtgt
//   Each posedge with reset==1:
//     stall==0: pc_if <= npc; instr_id <= instr_if; pc4_id <= pc_if + 4.
//     stall==1: pc_if, instr_id and pc4_id all hold. npc is discarded and recomputed
//       next cycle with fresh br/rs_fwd.
//   Delay slot: when a branch or jump is in ID, the slot instruction is the one at pc_if.
//     It is latched into ID normally, with no squash.
//   Latency: taken branch/jump in ID at cycle n -> target PC on pc_if at cycle n+1.
//     The target instruction reaches instr_id at cycle n+2.
//   Two-state view of IF/ID: RUN (stall==0, advance) / HOLD (stall==1, keep).
//     No other states exist; a stall of any length followed by release resumes exactly.
//   Reset released mid-stall: the first fetch is RESET_PC regardless of stall.
//   Simultaneous stall and taken branch: stall wins; the redirect takes effect on the
//     first non-stalled cycle.
//   redirect = (npc != pc_if + 4); it is evaluated independent of stall.
// TESTING
//   Reset: reset=0 for 2 cycles, then release -> pc_if=32'h3000, instr_id=0; then 3000,3004,3008 on successive cycles.
//   Taken beq: instr_id=32'h1000_0003 with pc4_id=32'h3008, npc_op=1, br=1 -> next pc_if=32'h3014; slot at 0x3008 enters ID.
//   Not-taken and negative offset: imm=16'hFFFE, pc4_id=32'h3010 -> br=0 gives pc_if+4; br=1 gives 32'h3008.
//   j/jr: instr_id=32'h0800_0C10 with npc_op=2 -> pc_if=32'h0000_3040; npc_op=3 with rs_fwd=32'h0000_3100 -> pc_if=32'h3100.
//   Stall: 3 stall cycles asserted while a taken branch is in ID -> pc_if/instr_id/pc4_id frozen; the branch target is applied on the cycle after release.
//   Wrap-around: pc_if=32'hFFFF_FFFC, npc_op=0 -> pc_if=32'h0000_0000; pc8_id wraps identically.

Source files
------------

// File: rtl/pc_npc_stage.sv
// Fetch PC register, IF/ID pipeline register and next-PC select.
// Delayed-branch fetch: the slot instruction always advances into ID.
module pc_npc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br,
    input  logic [31:0] rs_fwd,
    input  logic [31:0] instr_if,
    output logic [31:0] pc_if,
    output logic [31:0] instr_id,
    output logic [31:0] pc4_id,
    output logic [31:0] pc8_id,
    output logic        redirect
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] p4_q, p4_d;
    logic [31:0] seq, btgt, jtgt, npc;

    always_comb begin
        seq  = pc_q + 32'd4;
        btgt = p4_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        jtgt = {p4_q[31:28], ir_q[25:0], 2'b00};
        npc  = seq;
        unique case (npc_op)
            2'd0: npc = seq;
            2'd1: npc = br ? btgt : seq;
            2'd2: npc = jtgt;
            2'd3: npc = rs_fwd;
        endcase
    end

    // A stall freezes the whole fetch side; npc is simply dropped.
    always_comb begin
        pc_d = npc;
        ir_d = instr_if;
        p4_d = seq;
        if (stall) begin
            pc_d = pc_q;
            ir_d = ir_q;
            p4_d = p4_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            ir_q <= 32'h0;
            p4_q <= 32'h0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            p4_q <= p4_d;
        end
    end

    assign pc_if    = pc_q;
    assign instr_id = ir_q;
    assign pc4_id   = p4_q;
    assign pc8_id   = p4_q + 32'd4;
    assign redirect = (npc != seq);

endmodule

// File: tb/tb_pc_npc_stage.sv
// Bench for pc_npc_stage: directed vector table, reset/stall
// corner sequence, then random traffic against a reference model.
module tb_pc_npc_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  npc_op = 2'd0;
    logic        br = 1'b0;
    logic [31:0] rs_fwd = 32'h0;
    logic [31:0] instr_if = 32'h0;
    logic [31:0] pc_if, instr_id, pc4_id, pc8_id;
    logic        redirect;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_npc_stage dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .npc_op   (npc_op),
        .br       (br),
        .rs_fwd   (rs_fwd),
        .instr_if (instr_if),
        .pc_if    (pc_if),
        .instr_id (instr_id),
        .pc4_id   (pc4_id),
        .pc8_id   (pc8_id),
        .redirect (redirect)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic [1:0]  op;
        logic        b;
        logic [31:0] rs;
        logic [31:0] ii;
        logic        rdv;
        logic        rd;
        logic [31:0] epc;
        logic [31:0] eir;
        logic [31:0] ep4;
    } vec_t;

    vec_t tv[21];

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic [1:0] op,
        input logic b, input logic [31:0] rs, input logic [31:0] ii,
        input logic rdv, input logic rd, input logic [31:0] epc,
        input logic [31:0] eir, input logic [31:0] ep4);
        vec_t v;
        v.rst = rst; v.stl = stl; v.op = op; v.b = b;
        v.rs = rs; v.ii = ii; v.rdv = rdv; v.rd = rd;
        v.epc = epc; v.eir = eir; v.ep4 = ep4;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // reference model state
    logic [31:0] m_pc, m_ir, m_p4;

    function automatic logic [31:0] m_npc(input logic [1:0] op,
                                          input logic b,
                                          input logic [31:0] rs);
        int off;
        off = int'($signed(m_ir[15:0])) * 4;
        case (op)
            2'd1:    return b ? m_p4 + 32'(off) : m_pc + 32'd4;
            2'd2:    return (m_p4 & 32'hF000_0000) |
                            ((m_ir & 32'h03FF_FFFF) << 2);
            2'd3:    return rs;
            default: return m_pc + 32'd4;
        endcase
    endfunction

    task automatic post(input string nm, input logic [31:0] epc,
                        input logic [31:0] eir, input logic [31:0] ep4);
        chk({nm, ".pc_if"}, pc_if, epc);
        chk({nm, ".instr_id"}, instr_id, eir);
        chk({nm, ".pc4_id"}, pc4_id, ep4);
        chk({nm, ".pc8_id"}, pc8_id, ep4 + 32'd4);
    endtask

    initial begin
        tv[0]  = mk(0,0,0,0,0,32'h0, 0,0, 32'h3000,32'h0,32'h0);
        tv[1]  = mk(0,0,0,0,0,32'h0, 0,0, 32'h3000,32'h0,32'h0);
        tv[2]  = mk(1,0,0,0,0,32'h0, 1,0, 32'h3004,32'h0,32'h3004);
        tv[3]  = mk(1,0,0,0,0,32'h1000_0003, 1,0,
                    32'h3008,32'h1000_0003,32'h3008);
        tv[4]  = mk(1,0,1,1,0,32'h2108_0001, 1,1,
                    32'h3014,32'h2108_0001,32'h300C);
        tv[5]  = mk(1,0,0,0,0,32'h1440_FFFE, 1,0,
                    32'h3018,32'h1440_FFFE,32'h3018);
        tv[6]  = mk(1,0,1,0,0,32'h0000_0020, 1,0,
                    32'h301C,32'h0000_0020,32'h301C);
        tv[7]  = mk(1,0,0,0,0,32'h1440_FFFE, 1,0,
                    32'h3020,32'h1440_FFFE,32'h3020);
        tv[8]  = mk(1,0,1,1,0,32'h0000_0021, 1,1,
                    32'h3018,32'h0000_0021,32'h3024);
        tv[9]  = mk(1,0,0,0,0,32'h0800_0C10, 1,0,
                    32'h301C,32'h0800_0C10,32'h301C);
        tv[10] = mk(1,0,2,0,0,32'h0000_0022, 1,1,
                    32'h3040,32'h0000_0022,32'h3020);
        tv[11] = mk(1,0,0,0,0,32'h0060_0008, 1,0,
                    32'h3044,32'h0060_0008,32'h3044);
        tv[12] = mk(1,0,3,0,32'h3100,32'h0000_0023, 1,1,
                    32'h3100,32'h0000_0023,32'h3048);
        tv[13] = mk(1,0,0,0,0,32'h1000_0003, 1,0,
                    32'h3104,32'h1000_0003,32'h3104);
        tv[14] = mk(1,1,1,1,0,32'hDEAD_BEEF, 1,1,
                    32'h3104,32'h1000_0003,32'h3104);
        tv[15] = mk(1,1,1,1,0,32'hDEAD_BEEF, 1,1,
                    32'h3104,32'h1000_0003,32'h3104);
        tv[16] = mk(1,1,1,1,0,32'hDEAD_BEEF, 1,1,
                    32'h3104,32'h1000_0003,32'h3104);
        tv[17] = mk(1,0,1,1,0,32'h0000_0024, 1,1,
                    32'h3110,32'h0000_0024,32'h3108);
        tv[18] = mk(1,0,3,0,32'hFFFF_FFF8,32'h0, 1,1,
                    32'hFFFF_FFF8,32'h0,32'h3114);
        tv[19] = mk(1,0,0,0,0,32'h0, 1,0,
                    32'hFFFF_FFFC,32'h0,32'hFFFF_FFFC);
        tv[20] = mk(1,0,0,0,0,32'h0, 1,0,
                    32'h0,32'h0,32'h0);

        for (int i = 0; i < 21; i++) begin
            reset    = tv[i].rst;
            stall    = tv[i].stl;
            npc_op   = tv[i].op;
            br       = tv[i].b;
            rs_fwd   = tv[i].rs;
            instr_if = tv[i].ii;
            #1;
            if (tv[i].rdv)
                chk($sformatf("vec%0d.redirect", i),
                    {31'b0, redirect}, {31'b0, tv[i].rd});
            @(posedge clk);
            #1;
            post($sformatf("vec%0d", i), tv[i].epc, tv[i].eir, tv[i].ep4);
        end

        // reset wins over stall, and release mid-stall holds RESET_PC
        reset = 1'b0; stall = 1'b1; npc_op = 2'd3; rs_fwd = 32'h5555_0000;
        instr_if = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        post("rst_stall", 32'h3000, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        post("rel_stall", 32'h3000, 32'h0, 32'h0);
        stall = 1'b0; npc_op = 2'd0; instr_if = 32'h1234_5678;
        @(posedge clk); #1;
        post("first_fetch", 32'h3004, 32'h1234_5678, 32'h3004);

        m_pc = 32'h3004; m_ir = 32'h1234_5678; m_p4 = 32'h3004;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] nx;
            reset    = ($urandom_range(63) != 0);
            stall    = ($urandom_range(3) == 0);
            npc_op   = 2'($urandom_range(3));
            br       = 1'($urandom_range(1));
            rs_fwd   = $urandom;
            instr_if = $urandom;
            if ($urandom_range(7) == 0) rs_fwd = 32'hFFFF_FFFC;
            #1;
            nx = m_npc(npc_op, br, rs_fwd);
            chk("rnd.redirect", {31'b0, redirect},
                {31'b0, nx != m_pc + 32'd4});
            if (!reset) begin
                m_pc = 32'h3000; m_ir = 32'h0; m_p4 = 32'h0;
            end else if (!stall) begin
                m_p4 = m_pc + 32'd4;
                m_ir = instr_if;
                m_pc = nx;
            end
            @(posedge clk); #1;
            post("rnd", m_pc, m_ir, m_p4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
